rv_lsu: RTL
===========

# rv_lsu

Parametrised load/store unit placed between the RV32I core and data memory, generalising the core's single-cycle word-store data port. It adds byte, halfword, word and (when XLEN=64) doubleword loads and stores, byte-enable generation, and sign/zero extension. It also provides a wait-state request/acknowledge handshake to memory, misalignment and illegal-funct3 detection, and a programmable acknowledge timeout. The core stalls on oBusy and consumes results on the oDone pulse.

## Interface
- XLEN, 32: data width, 32 or 64; byte lanes NB = XLEN/8, offset width OW = log2(NB).
- ADDR_W, 32: address width.
- TIMEOUT, 255: maximum wait cycles for iMem_Ack; 0 disables the timeout.
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset, asynchronous, active-low.
- iReq  in  1  access request, sampled only when the unit can accept.
- iWe  in  1  1 = store, 0 = load.
- iFunct3  in  3  RV size/sign code.
- iAddr  in  ADDR_W  byte address.
- iWrData  in  XLEN  store data, right-aligned.
- oBusy  out  1  core stall.
- oDone  out  1  one-cycle completion pulse.
- oErr  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with oDone.
- oRdData  out  XLEN  extended load result.
- oMem_Req  out  1  memory request.
- oMem_WrEn  out  1  memory write.
- oMem_Addr  out  ADDR_W  address with low OW bits zeroed.
- oMem_ByteEn  out  NB  lane enables.
- oMem_WrData  out  XLEN  lane-positioned store data.
- iMem_Ack  in  1  memory acknowledge; read data valid in the same cycle.
- iMem_RdData  in  XLEN  memory read data.

## Operation
- funct3 codes:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - 011 D and 110 WU are legal only when XLEN=64.
  - 111, and BU/HU/WU with iWe=1, are illegal.
- Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0. Illegal funct3 takes priority over misaligned.
- States are IDLE, ACCESS and RESP.
- Acceptance: a request is accepted when iReq=1 in IDLE or RESP. All request fields are registered on that edge.
  - Legal request: go to ACCESS.
  - Error request: go to RESP with oErr set. Memory is never driven for an error request.
- ACCESS:
  - oMem_Req=1, with oMem_Addr, oMem_WrEn, oMem_ByteEn and oMem_WrData held stable until an ack or timeout.
  - On iMem_Ack: go to RESP with oErr=00. For a load, capture the extended data into oRdData.
  - Otherwise increment the wait counter. When the counter equals TIMEOUT (TIMEOUT≠0), go to RESP with oErr=11 and leave oRdData unchanged.
- RESP: oDone=1 for one cycle. With iReq=0 go to IDLE; with iReq=1 accept the new request (back-to-back).
- oBusy=1 exactly while in ACCESS. iReq is ignored in ACCESS.
- Store lanes (offset o = addr[OW-1:0]):
  - ByteEn is 1, 3, 0xF or 0xFF (by size), shifted left by o.
  - WrData repeats the low byte, halfword or word across all lanes.
- Load: shift iMem_RdData right by 8·o, then sign- or zero-extend from bit 7, 15 or 31.
- oRdData holds its value until the next successful load. Stores do not alter it.
- Reset: state IDLE, counter 0. All outputs are 0, including oRdData.
  - Reset asserted during ACCESS drops oMem_Req immediately (asynchronously).
  - No oDone is issued for the aborted access.

## Timing
- Request accepted at edge N.
- oMem_Req is high in cycle N+1.
- Ack in cycle N+k (k≥1) gives oDone, oErr and oRdData valid in cycle N+k+1.
  - Zero-wait memory therefore gives 2-cycle latency.
  - A new request can be accepted in that same RESP cycle.
- Error request: oDone in cycle N+1. oMem_Req never rises.
- Timeout: oDone with oErr=11 in cycle N+TIMEOUT+1.
- An ack arriving in the same cycle the counter reaches TIMEOUT counts as success.
- The wait counter is log2(TIMEOUT+1) bits wide and clears on every accept.
- iMem_Ack outside ACCESS is ignored.

## Structure
- Package lsu_pkg holds:
  - state enum lsu_state_e;
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU;
  - error codes ERR_OK, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT.
- Sub-module lsu_load_align, combinational and parametrised by XLEN: inputs are read data, offset and funct3; output is the extended result.
- The FSM, store-lane logic and counter live in rv_lsu.

## Test plan
- SB at XLEN=32: iAddr=0x1003, iWrData=0xAB, zero-wait ack.
  - Required: oMem_Addr=0x1000, ByteEn=0x8, WrData=0xABABABAB.
  - oDone two cycles after accept with oErr=00.
- LH then LHU: iAddr=0x2002, memory returns 0x8001_1234 after 3 wait cycles.
  - Required: LH gives oRdData=0xFFFF8001 and LHU gives 0x00008001.
  - oBusy is high for 4 cycles on each access.
- SW at 0x3002: oErr=01 one cycle after accept; oMem_Req stays 0.
- iFunct3=110 at XLEN=32: oErr=10.
- TIMEOUT=4 with no ack: oDone and oErr=11 five cycles after accept; oRdData unchanged.
- Back-to-back and reset cases:
  - Two loads issued back-to-back with zero-wait memory must give oDone pulses 2 cycles apart.
  - A second ACCESS cut by reset (iRst low) must drop oMem_Req asynchronously and produce no oDone.
- XLEN=64: LD at 0x8 returning 0x0123456789ABCDEF gives oRdData equal to that value.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: moves the addressed lanes down to bit 0 and
// sign- or zero-extends according to funct3.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   localparam int unsigned OW  = $clog2(XLEN / 8)
) (
   input  logic [XLEN-1:0] rdData,
   input  logic [OW-1:0]   offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = rdData >> {offset, 3'b000};
      case (funct3)
         F3_B:    result = XLEN'($signed(shifted[7:0]));
         F3_H:    result = XLEN'($signed(shifted[15:0]));
         F3_W:    result = XLEN'($signed(shifted[31:0]));
         F3_BU:   result = XLEN'(shifted[7:0]);
         F3_HU:   result = XLEN'(shifted[15:0]);
         F3_WU:   result = XLEN'(shifted[31:0]);
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit between the core and a wait-state data memory:
// request decode, store lane placement, ack handshake with timeout.
module rv_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iReq,
   input  logic              iWe,
   input  logic [2:0]        iFunct3,
   input  logic [ADDR_W-1:0] iAddr,
   input  logic [XLEN-1:0]   iWrData,
   output logic              oBusy,
   output logic              oDone,
   output logic [1:0]        oErr,
   output logic [XLEN-1:0]   oRdData,
   output logic              oMem_Req,
   output logic              oMem_WrEn,
   output logic [ADDR_W-1:0] oMem_Addr,
   output logic [XLEN/8-1:0] oMem_ByteEn,
   output logic [XLEN-1:0]   oMem_WrData,
   input  logic              iMem_Ack,
   input  logic [XLEN-1:0]   iMem_RdData
);

   localparam int unsigned NB   = XLEN / 8;
   localparam int unsigned OW   = $clog2(NB);
   localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          IS64 = (XLEN == 64);

   lsu_state_e        stateQ, stateD;
   logic [CW-1:0]     cntQ, cntD, cntInc;
   logic [2:0]        f3Q, f3D;
   logic [OW-1:0]     offQ, offD;
   logic              busyQ, busyD, doneQ, doneD;
   logic              memReqQ, memReqD, memWrEnQ, memWrEnD;
   logic [1:0]        errQ, errD, reqErr;
   logic [XLEN-1:0]   rdDataQ, rdDataD, loadExt;
   logic [XLEN-1:0]   wrDataQ, wrDataD, laneData;
   logic [ADDR_W-1:0] addrQ, addrD;
   logic [NB-1:0]     byteEnQ, byteEnD, laneBase, laneEn;
   logic              illegal, misalign;

   lsu_load_align #(.XLEN(XLEN)) uLoadAlign (
      .rdData (iMem_RdData),
      .offset (offQ),
      .funct3 (f3Q),
      .result (loadExt)
   );

   // Request classification; illegal funct3 outranks misalignment
   always_comb begin
      illegal = (iFunct3 == 3'b111) || (iWe && iFunct3[2]) ||
                (!IS64 && ((iFunct3 == F3_D) || (iFunct3 == F3_WU)));
      case (iFunct3[1:0])
         2'b01:   misalign = iAddr[0];
         2'b10:   misalign = |iAddr[1:0];
         2'b11:   misalign = |iAddr[2:0];
         default: misalign = 1'b0;
      endcase
      if (illegal)       reqErr = ERR_ILLEGAL;
      else if (misalign) reqErr = ERR_MISALIGN;
      else               reqErr = ERR_OK;
   end

   // Store lanes: enables shifted to the byte offset, data replicated
   always_comb begin
      case (iFunct3[1:0])
         2'b00: begin
            laneBase = NB'(1);
            laneData = {NB{iWrData[7:0]}};
         end
         2'b01: begin
            laneBase = NB'(3);
            laneData = {(NB/2){iWrData[15:0]}};
         end
         2'b10: begin
            laneBase = NB'(4'hF);
            laneData = {(NB/4){iWrData[31:0]}};
         end
         default: begin
            laneBase = NB'(8'hFF);
            laneData = iWrData;
         end
      endcase
      laneEn = laneBase << iAddr[OW-1:0];
   end

   always_comb begin
      stateD   = stateQ;
      cntD     = cntQ;
      cntInc   = cntQ + CW'(1);
      f3D      = f3Q;
      offD     = offQ;
      busyD    = 1'b0;
      doneD    = 1'b0;
      memReqD  = 1'b0;
      memWrEnD = 1'b0;
      errD     = errQ;
      rdDataD  = rdDataQ;
      addrD    = addrQ;
      byteEnD  = byteEnQ;
      wrDataD  = wrDataQ;
      case (stateQ)
         S_IDLE, S_RESP: begin
            if (iReq) begin
               cntD = '0;
               f3D  = iFunct3;
               offD = iAddr[OW-1:0];
               if (reqErr != ERR_OK) begin
                  stateD = S_RESP;
                  doneD  = 1'b1;
                  errD   = reqErr;
               end else begin
                  stateD   = S_ACCESS;
                  busyD    = 1'b1;
                  memReqD  = 1'b1;
                  memWrEnD = iWe;
                  addrD    = {iAddr[ADDR_W-1:OW], OW'(0)};
                  byteEnD  = laneEn;
                  wrDataD  = laneData;
               end
            end else begin
               stateD = S_IDLE;
            end
         end
         S_ACCESS: begin
            // An ack in the final wait cycle wins over the timeout
            if (iMem_Ack) begin
               stateD = S_RESP;
               doneD  = 1'b1;
               errD   = ERR_OK;
               if (!memWrEnQ) rdDataD = loadExt;
            end else if ((TIMEOUT != 0) && (cntInc == CW'(TIMEOUT))) begin
               stateD = S_RESP;
               doneD  = 1'b1;
               errD   = ERR_TIMEOUT;
            end else begin
               cntD     = cntInc;
               busyD    = 1'b1;
               memReqD  = 1'b1;
               memWrEnD = memWrEnQ;
            end
         end
         default: stateD = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         stateQ   <= S_IDLE;
         cntQ     <= '0;
         f3Q      <= '0;
         offQ     <= '0;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
         memReqQ  <= 1'b0;
         memWrEnQ <= 1'b0;
         errQ     <= ERR_OK;
         rdDataQ  <= '0;
         addrQ    <= '0;
         byteEnQ  <= '0;
         wrDataQ  <= '0;
      end else begin
         stateQ   <= stateD;
         cntQ     <= cntD;
         f3Q      <= f3D;
         offQ     <= offD;
         busyQ    <= busyD;
         doneQ    <= doneD;
         memReqQ  <= memReqD;
         memWrEnQ <= memWrEnD;
         errQ     <= errD;
         rdDataQ  <= rdDataD;
         addrQ    <= addrD;
         byteEnQ  <= byteEnD;
         wrDataQ  <= wrDataD;
      end
   end

   assign oBusy       = busyQ;
   assign oDone       = doneQ;
   assign oErr        = errQ;
   assign oRdData     = rdDataQ;
   assign oMem_Req    = memReqQ;
   assign oMem_WrEn   = memWrEnQ;
   assign oMem_Addr   = addrQ;
   assign oMem_ByteEn = byteEnQ;
   assign oMem_WrData = wrDataQ;

endmodule
